// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, one byte write per payload byte.
// Latency: first write is registered one cycle after the 5th byte handshake; sustains 1 byte/cycle.
// Backpressure: in_ready depends on state only; the upstream holds in_valid/in_data until accepted.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] bytes_written
);

    typedef enum logic [2:0] {IDLE, LEN, LOAD, DONE, ERR} state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] length;
    logic [1:0]  hdr_cnt;
    logic        hs;
    logic        can_start;
    logic [31:0] full_len;
    logic [32:0] end_addr;

    assign hs        = in_valid && in_ready;
    assign can_start = start && ((state == IDLE) || (state == ERR));
    // The 4th header byte is still on in_data when the length is judged.
    assign full_len  = {in_data, length[23:0]};
    assign end_addr  = {1'b0, BASE_ADDR} + {1'b0, full_len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LEN;
            LEN: begin
                if (hs && (hdr_cnt == 2'd3)) begin
                    if (full_len == 32'd0)
                        state_nxt = DONE;
                    else if (full_len[1:0] != 2'd0)
                        state_nxt = ERR;
                    else if (end_addr > MEM_LIMIT)
                        state_nxt = ERR;
                    else
                        state_nxt = LOAD;
                end
            end
            LOAD: if (hs && (bytes_written == length - 32'd1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            ERR:  if (start) state_nxt = LEN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 8'd0;
            bytes_written <= 32'd0;
            length        <= 32'd0;
            hdr_cnt       <= 2'd0;
        end else begin
            in_ready <= (state_nxt == LEN) || (state_nxt == LOAD);
            busy     <= (state_nxt == LEN) || (state_nxt == LOAD);
            done     <= (state_nxt == DONE);
            error    <= (state_nxt == ERR);
            mem_we   <= 1'b0;
            if (can_start) begin
                bytes_written <= 32'd0;
                length        <= 32'd0;
                hdr_cnt       <= 2'd0;
            end
            if ((state == LEN) && hs) begin
                case (hdr_cnt)
                    2'd0:    length[7:0]   <= in_data;
                    2'd1:    length[15:8]  <= in_data;
                    2'd2:    length[23:16] <= in_data;
                    default: length[31:24] <= in_data;
                endcase
                hdr_cnt <= hdr_cnt + 2'd1;
            end
            if ((state == LOAD) && hs) begin
                mem_we        <= 1'b1;
                mem_addr      <= BASE_ADDR + bytes_written;
                mem_wdata     <= in_data;
                bytes_written <= bytes_written + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a stream-level reference model predicts every output each cycle,
// and literal expectations pin the documented load scenarios.
module tb_imem_loader;

    localparam int unsigned MEM_BYTES = 65536;
    localparam logic [31:0] BASE_ADDR = 32'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] bytes_written;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting header, 2 collecting payload, 3 done cycle, 4 rejected.
    int          m_phase = 0;
    int          m_hdr_n = 0;
    longint      m_len = 0;
    logic        m_rdy = 0, m_busy = 0, m_we = 0, m_done = 0, m_err = 0;
    logic [31:0] m_addr = 0, m_bw = 0;
    logic [7:0]  m_wdata = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_hdr_n = 0; m_len = 0;
            m_rdy = 0; m_busy = 0; m_we = 0; m_done = 0; m_err = 0;
            m_addr = 0; m_bw = 0; m_wdata = 0;
        end else begin
            logic acc;
            acc = in_valid && m_rdy;
            m_we = 0;
            m_done = 0;
            case (m_phase)
                0, 4: if (start) begin
                    m_phase = 1; m_err = 0; m_bw = 0; m_hdr_n = 0; m_len = 0;
                end
                1: if (acc) begin
                    m_len = m_len + (longint'(in_data) << (8 * m_hdr_n));
                    m_hdr_n++;
                    if (m_hdr_n == 4) begin
                        if (m_len == 0) begin
                            m_phase = 3; m_done = 1;
                        end else if ((m_len % 4) != 0 || longint'(BASE_ADDR) + m_len > longint'(MEM_BYTES)) begin
                            m_phase = 4; m_err = 1;
                        end else begin
                            m_phase = 2;
                        end
                    end
                end
                2: if (acc) begin
                    m_we = 1; m_addr = BASE_ADDR + m_bw; m_wdata = in_data; m_bw = m_bw + 1;
                    if (longint'(m_bw) == m_len) begin
                        m_phase = 3; m_done = 1;
                    end
                end
                default: m_phase = 0;
            endcase
            m_rdy  = (m_phase == 1) || (m_phase == 2);
            m_busy = m_rdy;
        end
    end

    // Per-cycle comparison plus a byte memory fed by the DUT's write port.
    logic [7:0]  mem [int];
    int          n_we = 0, n_done = 0;
    logic [31:0] done_addr = 32'hffff_ffff;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("error", {31'd0, error}, {31'd0, m_err});
            chk("bytes_written", bytes_written, m_bw);
            if (m_we) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wdata});
            end
            if (mem_we) begin
                mem[int'(mem_addr)] = mem_wdata;
                n_we++;
            end
            if (done) begin
                n_done++;
                done_addr = mem_we ? mem_addr : 32'hffff_ffff;
            end
        end
    end

    function automatic logic [31:0] word_at(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic clear_stats();
        n_we = 0; n_done = 0; done_addr = 32'hffff_ffff; mem.delete();
    endtask

    task automatic idle(input int n, input logic v);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; in_valid = v; in_data = 8'h5a;
        end
    endtask

    task automatic pulse_start(input logic v);
        @(negedge clk);
        start = 1'b1; in_valid = v; in_data = 8'hc3;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input int gap_pct, input bit pulse);
        bit ok = 0;
        for (int g = 0; g < 3 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0;
        end
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = b; start = pulse && (t == 0);
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL handshake_timeout byte=%h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send(input logic [7:0] s[$], input int gap_pct, input int start_at);
        foreach (s[i]) push(s[i], gap_pct, i == start_at);
    endtask

    logic [7:0] basic[$] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h40, 8'h06,
                             8'h93, 8'h01, 8'h00, 8'h02};

    initial begin
        logic [7:0] s[$];
        int         k;
        int         w_before;

        #12;
        chk("reset_outputs", {in_ready, mem_we, busy, done, error, mem_wdata}, 13'd0);
        chk("reset_bytes_written", bytes_written, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b1);
        chk("idle_no_accept_before_start", {31'd0, in_ready}, 32'd0);

        // Basic load, start issued while in_valid is already high.
        clear_stats();
        pulse_start(1'b1);
        send(basic, 0, -1);
        idle(3, 1'b0);
        chk("basic_writes", n_we, 8);
        chk("basic_word0", word_at(0), 32'h0640_0093);
        chk("basic_word1", word_at(4), 32'h0200_0193);
        chk("basic_done_with_addr7", done_addr, 32'd7);
        chk("basic_bytes_written", bytes_written, 32'd8);

        // Same stream with random gaps.
        clear_stats();
        pulse_start(1'b0);
        send(basic, 50, -1);
        idle(3, 1'b0);
        chk("gaps_writes", n_we, 8);
        chk("gaps_word0", word_at(0), 32'h0640_0093);
        chk("gaps_word1", word_at(4), 32'h0200_0193);

        // Zero length; trailing bytes must be ignored.
        clear_stats();
        pulse_start(1'b0);
        s = '{8'h00, 8'h00, 8'h00, 8'h00};
        send(s, 0, -1);
        idle(4, 1'b1);
        chk("zero_done_count", n_done, 1);
        chk("zero_writes", n_we, 0);
        chk("zero_bytes_written", bytes_written, 32'd0);

        // Misaligned length.
        clear_stats();
        pulse_start(1'b0);
        s = '{8'h06, 8'h00, 8'h00, 8'h00};
        send(s, 0, -1);
        idle(3, 1'b1);
        chk("bad6_error", {31'd0, error}, 32'd1);
        chk("bad6_ready", {31'd0, in_ready}, 32'd0);
        chk("bad6_writes", n_we, 0);

        // Oversize length, restarted straight from the error state.
        pulse_start(1'b0);
        chk("restart_clears_error", {31'd0, error}, 32'd0);
        s = '{8'h04, 8'h00, 8'h01, 8'h00};
        send(s, 0, -1);
        idle(3, 1'b0);
        chk("big_error", {31'd0, error}, 32'd1);
        chk("big_writes", n_we, 0);
        pulse_start(1'b1);
        s = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde};
        send(s, 30, -1);
        idle(3, 1'b0);
        chk("recover_error", {31'd0, error}, 32'd0);
        chk("recover_word", word_at(0), 32'hdead_beef);
        chk("recover_done", n_done, 1);

        // Start pulsed mid-payload must be ignored.
        clear_stats();
        pulse_start(1'b0);
        send(basic, 20, 6);
        idle(3, 1'b0);
        chk("ign_start_writes", n_we, 8);
        chk("ign_start_bytes_written", bytes_written, 32'd8);
        chk("ign_start_word1", word_at(4), 32'h0200_0193);

        // Random loads.
        for (int r = 0; r < 6; r++) begin
            clear_stats();
            k = 4 * int'($urandom_range(1, 10));
            s = '{8'(k), 8'h00, 8'h00, 8'h00};
            for (int i = 0; i < k; i++) s.push_back(8'($urandom));
            pulse_start(1'($urandom));
            send(s, int'($urandom_range(0, 60)), -1);
            idle(2, 1'b0);
            chk("rand_writes", n_we, k);
            for (int i = 0; i < k; i++) chk("rand_mem", {24'd0, mem[i]}, {24'd0, s[i + 4]});
        end

        // Asynchronous reset after payload byte 3 of an 8-byte load.
        clear_stats();
        pulse_start(1'b0);
        s = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        send(s, 0, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {in_ready, mem_we, busy, done, error, mem_wdata}, 13'd0);
        chk("arst_bytes_written", bytes_written, 32'd0);
        w_before = n_we;
        idle(3, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b1);
        chk("arst_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_no_more_writes", n_we, w_before);
        chk("arst_written_before", n_we, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
